// File: rtl/lane_merge_2to1_if.sv
// Byte-lane bus between the 4:2 lane mux, the 2:1 lane merger and the
// next PHY stage. The slave modport is the merger's view; the master
// modport is the view of whatever drives the lanes and consumes the
// merged stream.
interface lane_merge_2to1_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [1:0]       valid_in;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             valid_out;
    logic             out_ready;
    logic             overflow;

    modport slave (
        input  in0,
        input  in1,
        input  valid_in,
        output in_ready,
        output out,
        output valid_out,
        input  out_ready,
        output overflow
    );

    modport master (
        output in0,
        output in1,
        output valid_in,
        input  in_ready,
        input  out,
        input  valid_out,
        output out_ready,
        input  overflow
    );
endinterface

// File: rtl/lane_merge_2to1.sv
// lane_merge_2to1: merges two byte lanes (up to 2 bytes/cycle) into one
// byte stream (1 byte/cycle) through a circular FIFO. Output order is
// arrival order, lane 0 before lane 1 within a cycle.
//
// Build option: define LANE_MERGE_OVF_DETECT_EN to enable the sticky
// overflow flag (set when bytes are offered while in_ready=0). Without it,
// overflow is tied low. The data path is the same in both builds.
//
// count_r tracks bytes held in the FIFO memory only; the byte presented
// on out is no longer counted once loaded into the output register.
module lane_merge_2to1 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    lane_merge_2to1_if.slave        bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and state
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] out_r;
    logic             valid_out_r;

    // Combinational helpers
    logic [CW-1:0]    free_s;
    logic             in_ready_s;
    logic             wr_en0_s;
    logic             wr_en1_s;
    logic [WIDTH-1:0] wr_data0_s;
    logic [WIDTH-1:0] wr_data1_s;
    logic [1:0]       nwr_s;
    logic             load_s;
    logic             drain_s;
    logic [AW-1:0]    wr_ptr_p1_s;
    logic [AW-1:0]    wr_ptr_next_s;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [CW-1:0]    count_next_s;

    // Space check uses the registered count only, so in_ready never
    // depends on this cycle's valid_in or out_ready.
    assign free_s      = CW'(DEPTH) - count_r;
    assign in_ready_s  = (free_s >= CW'(2));
    assign wr_ptr_p1_s = wr_ptr_r + AW'(1);

    // Decode which lanes are written this cycle and pack them so that the
    // first accepted byte always lands at wr_ptr and the second at wr_ptr+1.
    always_comb begin
        wr_en0_s   = 1'b0;
        wr_en1_s   = 1'b0;
        wr_data0_s = bus.in0;
        wr_data1_s = bus.in1;
        nwr_s      = 2'd0;
        if (in_ready_s) begin
            case (bus.valid_in)
                2'b11: begin
                    wr_en0_s   = 1'b1;
                    wr_en1_s   = 1'b1;
                    wr_data0_s = bus.in0;
                    wr_data1_s = bus.in1;
                    nwr_s      = 2'd2;
                end
                2'b01: begin
                    wr_en0_s   = 1'b1;
                    wr_data0_s = bus.in0;
                    nwr_s      = 2'd1;
                end
                2'b10: begin
                    wr_en0_s   = 1'b1;
                    wr_data0_s = bus.in1;
                    nwr_s      = 2'd1;
                end
                default: begin
                    wr_en0_s = 1'b0;
                    wr_en1_s = 1'b0;
                    nwr_s    = 2'd0;
                end
            endcase
        end else begin
            wr_en0_s = 1'b0;
            wr_en1_s = 1'b0;
            nwr_s    = 2'd0;
        end
    end

    // Output-stage decisions: load a new byte when the output register is
    // free or being consumed and the FIFO held data before this edge;
    // otherwise go idle when the held byte is consumed with nothing behind it.
    always_comb begin
        load_s  = 1'b0;
        drain_s = 1'b0;
        if ((!valid_out_r || bus.out_ready) && (count_r != CW'(0))) begin
            load_s = 1'b1;
        end else if (valid_out_r && bus.out_ready) begin
            drain_s = 1'b1;
        end else begin
            load_s  = 1'b0;
            drain_s = 1'b0;
        end
    end

    // Next pointer and occupancy values; a 2-push with a 1-pop nets +1.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r + AW'(nwr_s);
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r + CW'(nwr_s);
        if (load_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
            count_next_s  = count_r + CW'(nwr_s) - CW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
            count_next_s  = count_r + CW'(nwr_s);
        end
    end

    // FIFO memory write port; contents need no reset since pointers and
    // count define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en0_s) begin
                mem_r[wr_ptr_r] <= wr_data0_s;
            end
            if (wr_en1_s) begin
                mem_r[wr_ptr_p1_s] <= wr_data1_s;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Registered output byte and its valid flag; out keeps its last value
    // when the stream goes idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r       <= WIDTH'(0);
            valid_out_r <= 1'b0;
        end else if (load_s) begin
            out_r       <= mem_r[rd_ptr_r];
            valid_out_r <= 1'b1;
        end else if (drain_s) begin
            valid_out_r <= 1'b0;
        end
    end

`ifdef LANE_MERGE_OVF_DETECT_EN
    logic overflow_r;

    // Sticky flag: bytes were offered while there was no room; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (!in_ready_s && (bus.valid_in != 2'b00)) begin
            overflow_r <= 1'b1;
        end
    end

    assign bus.overflow = overflow_r;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out       = out_r;
    assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_lane_merge_2to1.sv
// Scoreboard bench for lane_merge_2to1: stimulus pushes the expected bytes
// into a queue as they are accepted; a separate monitor pops and compares
// on every output handshake. Directed checks cover reset, latency,
// ordering, backpressure with pointer wrap, overflow and mid-run reset.
module tb_lane_merge_2to1;

    logic clk;
    logic reset;

    lane_merge_2to1_if #(.WIDTH(8)) bus ();

    lane_merge_2to1 #(.WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         npops = 0;
    logic [7:0] last_pop = 8'h00;
    logic [7:0] sb[$];

`ifdef LANE_MERGE_OVF_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one cycle of lane data; acc is the hand-derived expectation of in_ready.
    task automatic push(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b, input logic acc);
        bus.valid_in = v;
        bus.in0      = a;
        bus.in1      = b;
        check("in_ready_before_write", 32'(bus.in_ready), 32'(acc));
        if (acc) begin
            if (v[0]) sb.push_back(a);
            if (v[1]) sb.push_back(b);
        end
        step();
        bus.valid_in = 2'b00;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare every consumed output byte against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.valid_out && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0h expected no byte at %0t", bus.out, $time);
            end else begin
                check("out_byte", 32'(bus.out), 32'(sb.pop_front()));
                npops++;
                last_pop = bus.out;
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.valid_in  = 2'b11;
        bus.in0       = 8'hAA;
        bus.in1       = 8'hBB;
        bus.out_ready = 1'b0;

        // Reset held 2 cycles with lanes active: everything ignored.
        step();
        step();
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_valid_out", 32'(bus.valid_out), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        reset        = 1'b0;
        bus.valid_in = 2'b00;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_fifo_empty", 32'(bus.valid_out), 32'h0);

        // Single lane: byte visible two edges after being offered.
        push(2'b01, 8'hBC, 8'h00, 1'b1);
        check("single_lat_e1", 32'(bus.valid_out), 32'h0);
        step();
        check("single_lat_e2_valid", 32'(bus.valid_out), 32'h1);
        check("single_lat_e2_out", 32'(bus.out), 32'hBC);
        step();
        check("single_after_valid", 32'(bus.valid_out), 32'h0);

        // Ordering: lane 0 before lane 1, then the next cycle's byte.
        push(2'b11, 8'h11, 8'h22, 1'b1);
        push(2'b10, 8'h00, 8'h33, 1'b1);
        check("order_b0", 32'(bus.out), 32'h11);
        step();
        check("order_b1", 32'(bus.out), 32'h22);
        step();
        check("order_b2", 32'(bus.out), 32'h33);
        step();
        check("order_idle", 32'(bus.valid_out), 32'h0);

        // Fill with downstream stalled: counts 2,3,5,7 -> in_ready drops after 4th write.
        bus.out_ready = 1'b0;
        push(2'b11, 8'h40, 8'h41, 1'b1);
        push(2'b11, 8'h42, 8'h43, 1'b1);
        push(2'b11, 8'h44, 8'h45, 1'b1);
        push(2'b11, 8'h46, 8'h47, 1'b1);
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        push(2'b01, 8'hEE, 8'h00, 1'b0);
        check("overflow_set", 32'(bus.overflow), 32'(OVF_EXP));
        push(2'b10, 8'h00, 8'hEF, 1'b0);
        step();
        check("overflow_sticky", 32'(bus.overflow), 32'(OVF_EXP));
        check("full_hold_valid", 32'(bus.valid_out), 32'h1);
        check("full_hold_out", 32'(bus.out), 32'h40);
        bus.out_ready = 1'b1;
        drain("fill_drain_done");
        step();
        check("fill_idle_valid", 32'(bus.valid_out), 32'h0);
        check("fill_idle_in_ready", 32'(bus.in_ready), 32'h1);

        // Mid-operation reset with 5 bytes buffered and one on out.
        bus.out_ready = 1'b0;
        push(2'b11, 8'h50, 8'h51, 1'b1);
        push(2'b11, 8'h52, 8'h53, 1'b1);
        push(2'b11, 8'h54, 8'h55, 1'b1);
        check("midrst_pre_valid", 32'(bus.valid_out), 32'h1);
        reset        = 1'b1;
        bus.valid_in = 2'b11;
        bus.in0      = 8'h77;
        bus.in1      = 8'h78;
        step();
        sb.delete();
        check("midrst_valid_out", 32'(bus.valid_out), 32'h0);
        check("midrst_out", 32'(bus.out), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        check("midrst_overflow", 32'(bus.overflow), 32'h0);
        reset        = 1'b0;
        bus.valid_in = 2'b00;
        push(2'b01, 8'h5A, 8'h00, 1'b1);
        bus.out_ready = 1'b1;
        drain("midrst_drain_done");
        check("midrst_first_byte", 32'(last_pop), 32'h5A);
        step();
        check("midrst_idle", 32'(bus.valid_out), 32'h0);
        check("total_pops", 32'(npops), 32'd13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
